memory_unit_ls: RTL and testbench

MEMORY_UNIT_LS -- requirements
Module: memory_unit_ls

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_lane_align.sv | 59 +++++
 rtl/memory_unit_ls.sv | 137 +++++++++++++
 tb/tb_memory_unit_ls.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the load/store memory unit: access sizes, FSM states
// and the alignment rule used at request acceptance.
package mem_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // An access of 2**size bytes must start on a 2**size byte boundary.
   function automatic logic misaligned(input logic [2:0] lo, input logic [1:0] size);
      case (size)
         SZ_B:    return 1'b0;
         SZ_H:    return lo[0];
         SZ_W:    return |lo[1:0];
         default: return |lo;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: byte enables and store-data placement for writes,
// lane extraction plus sign/zero extension for loads.
module mem_lane_align
   import mem_pkg::*;
#(
   parameter int WORDSIZE = 32,
   localparam int NB = WORDSIZE / 8,
   localparam int OB = $clog2(NB)
) (
   input  logic [OB-1:0]       offset,
   input  logic [1:0]          size,
   input  logic                uns,
   input  logic [WORDSIZE-1:0] wdata,
   input  logic [WORDSIZE-1:0] rdata,
   output logic [NB-1:0]       be,
   output logic [WORDSIZE-1:0] wlanes,
   output logic [WORDSIZE-1:0] rext
);

   logic [4:0]          nlanes;
   logic [4:0]          off5;
   logic [WORDSIZE-1:0] sh;
   logic [WORDSIZE-1:0] keep;
   logic                top;

   assign nlanes = 5'd1 << size;
   assign off5   = 5'(offset);

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_be
         localparam logic [4:0] LANE = 5'(gi);
         assign be[gi] = (LANE >= off5) && (LANE < off5 + nlanes);
      end
   endgenerate

   assign wlanes = wdata << {offset, 3'b000};
   assign sh     = rdata >> {offset, 3'b000};

   // A full-width access keeps every bit, so ~keep is zero and uns has no effect.
   always_comb begin
      keep = '1;
      top  = sh[31];
      case (size)
         SZ_B: begin
            keep = WORDSIZE'(8'hFF);
            top  = sh[7];
         end
         SZ_H: begin
            keep = WORDSIZE'(16'hFFFF);
            top  = sh[15];
         end
         SZ_W:    keep = WORDSIZE'(32'hFFFF_FFFF);
         default: keep = '1;
      endcase
      rext = (sh & keep) | ({WORDSIZE{~uns & top}} & ~keep);
   end

endmodule

// File: rtl/memory_unit_ls.sv
// Byte-addressable load/store memory with optional wait states, a
// registered-read word array and a four-state request FSM.
module memory_unit_ls
   import mem_pkg::*;
#(
   parameter int ADDRSIZE    = 16,
   parameter int WORDSIZE    = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wren,
   input  logic                rden,
   input  logic [ADDRSIZE-1:0] addr,
   input  logic [1:0]          size,
   input  logic                uns,
   input  logic [WORDSIZE-1:0] d,
   output logic [WORDSIZE-1:0] q,
   output logic                busy,
   output logic                ack,
   output logic                err
);

   localparam int NB    = WORDSIZE / 8;
   localparam int OB    = $clog2(NB);
   localparam int IW    = ADDRSIZE - OB;
   localparam int DEPTH = 2 ** IW;

   logic [WORDSIZE-1:0] mem [DEPTH];

   state_t              state_reg;
   logic [3:0]          cnt_reg;
   logic [ADDRSIZE-1:0] addr_reg;
   logic [1:0]          size_reg;
   logic                uns_reg;
   logic                store_reg;
   logic [WORDSIZE-1:0] d_reg;
   logic [WORDSIZE-1:0] q_reg;
   logic [WORDSIZE-1:0] rdata_reg;
   logic                busy_reg;
   logic                ack_reg;
   logic                err_reg;

   logic [NB-1:0]       be;
   logic [WORDSIZE-1:0] wlanes;
   logic [WORDSIZE-1:0] rext;
   logic [IW-1:0]       acc_idx;
   logic [IW-1:0]       rd_idx;
   logic                we;
   logic                bad_req;

   assign acc_idx = addr_reg[ADDRSIZE-1:OB];
   // Read the incoming address while idle so the word is ready by ACCESS.
   assign rd_idx  = (state_reg == ST_IDLE) ? addr[ADDRSIZE-1:OB] : acc_idx;
   assign we      = (state_reg == ST_ACCESS) && store_reg && !rst;
   assign bad_req = (wren && rden) || (size == SZ_D && WORDSIZE == 32) ||
                    misaligned(addr[2:0], size);

   mem_lane_align #(.WORDSIZE(WORDSIZE)) u_align (
      .offset (addr_reg[OB-1:0]),
      .size   (size_reg),
      .uns    (uns_reg),
      .wdata  (d_reg),
      .rdata  (rdata_reg),
      .be     (be),
      .wlanes (wlanes),
      .rext   (rext)
   );

   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (we && be[i]) mem[acc_idx][i*8 +: 8] <= wlanes[i*8 +: 8];
      end
      rdata_reg <= mem[rd_idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= 4'd0;
         busy_reg  <= 1'b0;
         ack_reg   <= 1'b0;
         err_reg   <= 1'b0;
         q_reg     <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               ack_reg <= 1'b0;
               err_reg <= 1'b0;
               if (wren || rden) begin
                  addr_reg  <= addr;
                  size_reg  <= size;
                  uns_reg   <= uns;
                  d_reg     <= d;
                  store_reg <= wren;
                  busy_reg  <= 1'b1;
                  if (bad_req) begin
                     state_reg <= ST_DONE;
                     ack_reg   <= 1'b1;
                     err_reg   <= 1'b1;
                  end else if (WAIT_STATES > 0) begin
                     state_reg <= ST_WAIT;
                  end else begin
                     state_reg <= ST_ACCESS;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_reg == 4'(WAIT_STATES - 1)) begin
                  cnt_reg   <= 4'd0;
                  state_reg <= ST_ACCESS;
               end else begin
                  cnt_reg <= cnt_reg + 4'd1;
               end
            end
            ST_ACCESS: begin
               if (!store_reg) q_reg <= rext;
               state_reg <= ST_DONE;
               ack_reg   <= 1'b1;
               err_reg   <= 1'b0;
            end
            default: begin
               state_reg <= ST_IDLE;
               ack_reg   <= 1'b0;
               err_reg   <= 1'b0;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign q    = q_reg;
   assign busy = busy_reg;
   assign ack  = ack_reg;
   assign err  = err_reg;

endmodule

// File: tb/tb_memory_unit_ls.sv
// Bench for memory_unit_ls: one instance without wait states and one with
// three, checked against a byte-addressed little-endian memory model.
module tb_memory_unit_ls;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0, wren0, rden0, uns0, busy0, ack0, err0;
   logic [15:0] addr0;
   logic [1:0]  size0;
   logic [31:0] d0, q0;
   logic        rst1, wren1, rden1, uns1, busy1, ack1, err1;
   logic [15:0] addr1;
   logic [1:0]  size1;
   logic [31:0] d1, q1;

   memory_unit_ls #(.ADDRSIZE(16), .WORDSIZE(32), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst0), .wren(wren0), .rden(rden0), .addr(addr0), .size(size0),
      .uns(uns0), .d(d0), .q(q0), .busy(busy0), .ack(ack0), .err(err0));

   memory_unit_ls #(.ADDRSIZE(16), .WORDSIZE(32), .WAIT_STATES(3)) dut1 (
      .clk(clk), .rst(rst1), .wren(wren1), .rden(rden1), .addr(addr1), .size(size1),
      .uns(uns1), .d(d1), .q(q1), .busy(busy1), .ack(ack1), .err(err1));

   int checks = 0;
   int errors = 0;

   // Reference model: plain byte memory per instance plus the last loaded value.
   logic [7:0]  mm [2][65536];
   logic [31:0] mq [2];

   function automatic int wsof(input int w);
      return (w == 0) ? 0 : 3;
   endfunction

   function automatic logic [31:0] model_read(input int w, input logic [15:0] a,
                                              input logic [1:0] sz, input logic u);
      int n;
      logic [63:0] v;
      n = 1 << sz;
      v = 64'd0;
      for (int k = 0; k < n; k++) v = v | (64'(mm[w][16'(a + 16'(k))]) << (8 * k));
      if (!u && n < 4 && ((v >> (8 * n - 1)) & 64'd1) == 64'd1)
         v = v | ~((64'd1 << (8 * n)) - 64'd1);
      return v[31:0];
   endfunction

   task automatic model_apply(input int w, input logic wr, input logic rd, input logic [15:0] a,
                              input logic [1:0] sz, input logic u, input logic [31:0] dt,
                              output logic [31:0] eq, output logic ee, output int el);
      int n;
      n  = 1 << sz;
      ee = (wr && rd) || (sz == 2'd3) || ((int'(a) % n) != 0);
      if (ee) begin
         el = 0;
      end else begin
         el = 1 + wsof(w);
         if (wr) for (int k = 0; k < n; k++) mm[w][16'(a + 16'(k))] = 8'(dt >> (8 * k));
         else mq[w] = model_read(w, a, sz, u);
      end
      eq = mq[w];
   endtask

   task automatic set_in(input int w, input logic wr, input logic rd, input logic [15:0] a,
                         input logic [1:0] sz, input logic u, input logic [31:0] dt);
      if (w == 0) begin
         wren0 = wr; rden0 = rd; addr0 = a; size0 = sz; uns0 = u; d0 = dt;
      end else begin
         wren1 = wr; rden1 = rd; addr1 = a; size1 = sz; uns1 = u; d1 = dt;
      end
   endtask

   task automatic get_out(input int w, output logic [31:0] oq, output logic ob,
                          output logic oa, output logic oe);
      if (w == 0) begin
         oq = q0; ob = busy0; oa = ack0; oe = err0;
      end else begin
         oq = q1; ob = busy1; oa = ack1; oe = err1;
      end
   endtask

   // Issue one request; lat counts edges after the accepting edge until ack is seen.
   task automatic run_op(input int w, input logic wr, input logic rd, input logic [15:0] a,
                         input logic [1:0] sz, input logic u, input logic [31:0] dt, input bit noise,
                         output logic [31:0] oq, output logic oe, output int lat,
                         output logic b_first, output logic a_after, output logic b_after);
      logic        oa, ob, de;
      logic [31:0] dq;
      @(negedge clk);
      set_in(w, wr, rd, a, sz, u, dt);
      @(posedge clk); #1;
      if (noise) set_in(w, 1'b1, 1'b0, 16'h0040, 2'd2, 1'b0, 32'hA5A5_A5A5);
      else       set_in(w, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 32'h0);
      get_out(w, oq, ob, oa, oe);
      b_first = ob;
      lat = 0;
      while (oa !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         get_out(w, oq, ob, oa, oe);
      end
      set_in(w, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 32'h0);
      @(posedge clk); #1;
      get_out(w, dq, b_after, a_after, de);
      $display("[%0t] dut%0d %s a=%h sz=%0d u=%0d d=%h -> q=%h err=%0b lat=%0d", $time, w,
               (wr && rd) ? "both" : (wr ? "st" : "ld"), a, sz, u, dt, oq, oe, lat);
   endtask

   task automatic test_reset;
      logic [31:0] q;
      logic b, a, e;
      rst0 = 1'b1; rst1 = 1'b1;
      set_in(0, 1'b1, 1'b0, 16'h0, 2'd2, 1'b0, 32'h0);
      set_in(1, 1'b0, 1'b1, 16'h0, 2'd2, 1'b0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      for (int w = 0; w < 2; w++) begin
         get_out(w, q, b, a, e);
         mq[w] = 32'h0;
         checks++;
         if (q !== 32'h0 || b !== 1'b0 || a !== 1'b0 || e !== 1'b0) begin
            errors++;
            $display("FAIL reset dut%0d: got q=%h busy=%b ack=%b err=%b, want 0/0/0/0", w, q, b, a, e);
         end
      end
      set_in(0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 32'h0);
      set_in(1, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 32'h0);
      @(negedge clk);
      rst0 = 1'b0; rst1 = 1'b0;
      $display("[%0t] reset released", $time);
   endtask

   task automatic test_store_load(input int w);
      logic [31:0] q, eq;
      logic e, ee, b0, aa, ba;
      int lat, el;
      model_apply(w, 1, 0, 16'h0010, 2'd2, 0, 32'hDEADBEEF, eq, ee, el);
      run_op(w, 1, 0, 16'h0010, 2'd2, 0, 32'hDEADBEEF, 0, q, e, lat, b0, aa, ba);
      checks++;
      if (e !== 1'b0 || lat != 1 + wsof(w) || aa !== 1'b0 || ba !== 1'b0) begin
         errors++;
         $display("FAIL st_word dut%0d: got err=%b lat=%0d ack_after=%b busy_after=%b, want 0/%0d/0/0",
                  w, e, lat, aa, ba, 1 + wsof(w));
      end
      model_apply(w, 0, 1, 16'h0010, 2'd2, 0, 32'h0, eq, ee, el);
      run_op(w, 0, 1, 16'h0010, 2'd2, 0, 32'h0, 0, q, e, lat, b0, aa, ba);
      checks++;
      if (q !== 32'hDEADBEEF || e !== 1'b0 || lat != 1 + wsof(w)) begin
         errors++;
         $display("FAIL ld_word dut%0d: got q=%h err=%b lat=%0d, want DEADBEEF/0/%0d", w, q, e, lat, 1 + wsof(w));
      end
      model_apply(w, 1, 0, 16'h0013, 2'd0, 0, 32'h80, eq, ee, el);
      run_op(w, 1, 0, 16'h0013, 2'd0, 0, 32'h80, 0, q, e, lat, b0, aa, ba);
      model_apply(w, 0, 1, 16'h0013, 2'd0, 0, 32'h0, eq, ee, el);
      run_op(w, 0, 1, 16'h0013, 2'd0, 0, 32'h0, 0, q, e, lat, b0, aa, ba);
      checks++;
      if (q !== 32'hFFFFFF80 || e !== 1'b0) begin
         errors++;
         $display("FAIL ld_byte_signed dut%0d: got q=%h err=%b, want FFFFFF80/0", w, q, e);
      end
      model_apply(w, 0, 1, 16'h0013, 2'd0, 1, 32'h0, eq, ee, el);
      run_op(w, 0, 1, 16'h0013, 2'd0, 1, 32'h0, 0, q, e, lat, b0, aa, ba);
      checks++;
      if (q !== 32'h00000080) begin
         errors++;
         $display("FAIL ld_byte_unsigned dut%0d: got q=%h, want 00000080", w, q);
      end
      model_apply(w, 0, 1, 16'h0010, 2'd2, 0, 32'h0, eq, ee, el);
      run_op(w, 0, 1, 16'h0010, 2'd2, 0, 32'h0, 0, q, e, lat, b0, aa, ba);
      checks++;
      if (q !== 32'h80ADBEEF) begin
         errors++;
         $display("FAIL ld_word_merged dut%0d: got q=%h, want 80ADBEEF", w, q);
      end
   endtask

   task automatic test_misaligned(input int w);
      logic [31:0] q, eq;
      logic e, ee, b0, aa, ba;
      int lat, el;
      model_apply(w, 0, 1, 16'h0011, 2'd1, 0, 32'h0, eq, ee, el);
      run_op(w, 0, 1, 16'h0011, 2'd1, 0, 32'h0, 0, q, e, lat, b0, aa, ba);
      checks++;
      if (e !== 1'b1 || lat != 0 || q !== 32'h80ADBEEF || b0 !== 1'b1 || aa !== 1'b0) begin
         errors++;
         $display("FAIL misaligned_half dut%0d: got err=%b lat=%0d q=%h busy=%b ack_after=%b, want 1/0/80ADBEEF/1/0",
                  w, e, lat, q, b0, aa);
      end
      model_apply(w, 0, 1, 16'h0010, 2'd2, 0, 32'h0, eq, ee, el);
      run_op(w, 0, 1, 16'h0010, 2'd2, 0, 32'h0, 0, q, e, lat, b0, aa, ba);
      checks++;
      if (q !== 32'h80ADBEEF || e !== 1'b0) begin
         errors++;
         $display("FAIL after_misaligned dut%0d: got q=%h err=%b, want 80ADBEEF/0", w, q, e);
      end
   endtask

   task automatic test_illegal(input int w);
      logic [31:0] q, eq;
      logic e, ee, b0, aa, ba;
      int lat, el;
      model_apply(w, 1, 1, 16'h0010, 2'd2, 0, 32'h11111111, eq, ee, el);
      run_op(w, 1, 1, 16'h0010, 2'd2, 0, 32'h11111111, 0, q, e, lat, b0, aa, ba);
      checks++;
      if (e !== 1'b1 || lat != 0) begin
         errors++;
         $display("FAIL both_high dut%0d: got err=%b lat=%0d, want 1/0", w, e, lat);
      end
      model_apply(w, 1, 0, 16'h0010, 2'd3, 0, 32'h22222222, eq, ee, el);
      run_op(w, 1, 0, 16'h0010, 2'd3, 0, 32'h22222222, 0, q, e, lat, b0, aa, ba);
      checks++;
      if (e !== 1'b1 || lat != 0) begin
         errors++;
         $display("FAIL size3_store dut%0d: got err=%b lat=%0d, want 1/0", w, e, lat);
      end
      model_apply(w, 0, 1, 16'h0018, 2'd3, 0, 32'h0, eq, ee, el);
      run_op(w, 0, 1, 16'h0018, 2'd3, 0, 32'h0, 0, q, e, lat, b0, aa, ba);
      checks++;
      if (e !== 1'b1 || q !== 32'h80ADBEEF) begin
         errors++;
         $display("FAIL size3_load dut%0d: got err=%b q=%h, want 1/80ADBEEF", w, e, q);
      end
      model_apply(w, 0, 1, 16'h0010, 2'd2, 0, 32'h0, eq, ee, el);
      run_op(w, 0, 1, 16'h0010, 2'd2, 0, 32'h0, 0, q, e, lat, b0, aa, ba);
      checks++;
      if (q !== 32'h80ADBEEF || e !== 1'b0) begin
         errors++;
         $display("FAIL after_illegal dut%0d: got q=%h err=%b, want 80ADBEEF/0", w, q, e);
      end
   endtask

   task automatic test_back_to_back;
      int  acks;
      bit  prev, consec;
      acks = 0; prev = 0; consec = 0;
      @(negedge clk);
      set_in(0, 1'b0, 1'b1, 16'h0010, 2'd2, 1'b0, 32'h0);
      repeat (9) begin
         @(posedge clk); #1;
         if (ack0 === 1'b1) begin
            acks++;
            if (prev) consec = 1;
         end
         prev = (ack0 === 1'b1);
      end
      set_in(0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 32'h0);
      $display("[%0t] dut0 held load over 9 edges -> acks=%0d q=%h", $time, acks, q0);
      checks++;
      if (acks != 3 || consec || q0 !== 32'h80ADBEEF) begin
         errors++;
         $display("FAIL back_to_back: got acks=%0d adjacent=%0d q=%h, want 3/0/80ADBEEF", acks, consec, q0);
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_wait_busy;
      logic [31:0] q, eq;
      logic e, ee, b0, aa, ba;
      int lat, el;
      model_apply(1, 1, 0, 16'h0040, 2'd2, 0, 32'h01020304, eq, ee, el);
      run_op(1, 1, 0, 16'h0040, 2'd2, 0, 32'h01020304, 0, q, e, lat, b0, aa, ba);
      model_apply(1, 0, 1, 16'h0040, 2'd2, 0, 32'h0, eq, ee, el);
      run_op(1, 0, 1, 16'h0040, 2'd2, 0, 32'h0, 1, q, e, lat, b0, aa, ba);
      checks++;
      if (lat != 4 || e !== 1'b0 || q !== 32'h01020304 || aa !== 1'b0) begin
         errors++;
         $display("FAIL wait_load: got lat=%0d err=%b q=%h ack_after=%b, want 4/0/01020304/0", lat, e, q, aa);
      end
      model_apply(1, 0, 1, 16'h0040, 2'd2, 0, 32'h0, eq, ee, el);
      run_op(1, 0, 1, 16'h0040, 2'd2, 0, 32'h0, 0, q, e, lat, b0, aa, ba);
      checks++;
      if (q !== 32'h01020304) begin
         errors++;
         $display("FAIL busy_ignore: got q=%h, want 01020304", q);
      end
   endtask

   task automatic test_reset_in_wait;
      logic [31:0] q, eq;
      logic e, ee, b0, aa, ba;
      int lat, el, acks;
      model_apply(1, 1, 0, 16'h0020, 2'd2, 0, 32'hCAFEF00D, eq, ee, el);
      run_op(1, 1, 0, 16'h0020, 2'd2, 0, 32'hCAFEF00D, 0, q, e, lat, b0, aa, ba);
      @(negedge clk);
      set_in(1, 1'b1, 1'b0, 16'h0020, 2'd2, 1'b0, 32'h12345678);
      @(posedge clk); #1;
      set_in(1, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 32'h0);
      rst1 = 1'b1;
      @(posedge clk); #1;
      rst1 = 1'b0;
      mq[1] = 32'h0;
      $display("[%0t] dut1 reset during WAIT -> busy=%b ack=%b q=%h", $time, busy1, ack1, q1);
      checks++;
      if (busy1 !== 1'b0 || ack1 !== 1'b0 || q1 !== 32'h0) begin
         errors++;
         $display("FAIL reset_in_wait: got busy=%b ack=%b q=%h, want 0/0/0", busy1, ack1, q1);
      end
      acks = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (ack1 === 1'b1) acks++;
      end
      checks++;
      if (acks != 0) begin
         errors++;
         $display("FAIL aborted_ack: got %0d ack pulses, want 0", acks);
      end
      model_apply(1, 0, 1, 16'h0020, 2'd2, 0, 32'h0, eq, ee, el);
      run_op(1, 0, 1, 16'h0020, 2'd2, 0, 32'h0, 0, q, e, lat, b0, aa, ba);
      checks++;
      if (q !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL aborted_write: got q=%h, want CAFEF00D", q);
      end
   endtask

   task automatic test_random(input int w);
      logic [31:0] q, eq, dt;
      logic e, ee, b0, aa, ba, wr, rd, u;
      logic [15:0] a;
      logic [1:0]  sz;
      int lat, el, r;
      for (int k = 0; k < 16; k++) begin
         a  = 16'h0100 + 16'(4 * k);
         dt = $urandom;
         model_apply(w, 1, 0, a, 2'd2, 0, dt, eq, ee, el);
         run_op(w, 1, 0, a, 2'd2, 0, dt, 0, q, e, lat, b0, aa, ba);
         checks++;
         if (e !== ee || lat != el) begin
            errors++;
            $display("FAIL rnd_init dut%0d a=%h: got err=%b lat=%0d, want %b/%0d", w, a, e, lat, ee, el);
         end
      end
      for (int n = 0; n < 40; n++) begin
         r  = int'($urandom_range(0, 9));
         wr = (r <= 4);
         rd = (r == 0) || (r >= 5);
         sz = 2'($urandom_range(0, 3));
         a  = 16'h0100 + 16'($urandom_range(0, 63));
         u  = 1'($urandom_range(0, 1));
         dt = $urandom;
         model_apply(w, wr, rd, a, sz, u, dt, eq, ee, el);
         run_op(w, wr, rd, a, sz, u, dt, 0, q, e, lat, b0, aa, ba);
         checks++;
         if (e !== ee || lat != el) begin
            errors++;
            $display("FAIL rnd_status dut%0d a=%h sz=%0d: got err=%b lat=%0d, want %b/%0d", w, a, sz, e, lat, ee, el);
         end
         checks++;
         if (q !== eq) begin
            errors++;
            $display("FAIL rnd_q dut%0d a=%h sz=%0d u=%b: got q=%h, want %h", w, a, sz, u, q, eq);
         end
         checks++;
         if (b0 !== 1'b1 || aa !== 1'b0 || ba !== 1'b0) begin
            errors++;
            $display("FAIL rnd_handshake dut%0d: got busy=%b ack_after=%b busy_after=%b, want 1/0/0", w, b0, aa, ba);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      for (int w = 0; w < 2; w++) begin
         test_store_load(w);
         test_misaligned(w);
         test_illegal(w);
      end
      test_back_to_back();
      test_wait_busy();
      test_reset_in_wait();
      for (int w = 0; w < 2; w++) test_random(w);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
